// File: rtl/tile_tone_player_if.sv
// Note-request and sample-write handshake bundle between the note source,
// the tone player and the audio codec controller.
interface tile_tone_player_if;
    logic        note_valid;
    logic [3:0]  note;
    logic        note_ready;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] sample_out;
    logic        busy;
    logic [3:0]  cur_note;

    modport master (
        output note_valid, note, audio_out_allowed,
        input  note_ready, write_audio_out, sample_out, busy, cur_note
    );

    modport slave (
        input  note_valid, note, audio_out_allowed,
        output note_ready, write_audio_out, sample_out, busy, cur_note
    );
endinterface

// File: rtl/tile_tone_player.sv
// Queues note codes and plays each as a square wave for NOTE_SAMPLES ticks plus a silent gap.
// Optional decay on the second half of each note: define TILE_TONE_ENVELOPE_EN.
module tile_tone_player #(
    parameter int          NOTE_SAMPLES = 12000,
    parameter int          GAP_SAMPLES  = 1200,
    parameter logic [31:0] AMPLITUDE    = 32'd10000000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    tile_tone_player_if.slave bus
);

    localparam int CNT_MAX = (NOTE_SAMPLES > GAP_SAMPLES) ? NOTE_SAMPLES : GAP_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    logic [3:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_fifo_cnt;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] w_sample_cnt_next;
    logic [18:0]      r_half_cnt;
    logic [18:0]      w_half_cnt_next;
    logic             r_snd;
    logic             w_snd_next;
    logic [3:0]       r_cur_note;
    logic [3:0]       w_cur_note_next;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_tick;
    logic [18:0]      w_delay;
    logic [31:0]      w_mag;

    assign w_full  = (r_fifo_cnt == FIFO_FULL);
    assign w_empty = (r_fifo_cnt == '0);
    // Rests complete the handshake but never occupy a slot.
    assign w_push  = bus.note_valid && !w_full && (bus.note != 4'd0);
    assign w_tick  = bus.audio_out_allowed;
    assign w_delay = {r_cur_note, 15'd3000};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= bus.note;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_sample_cnt <= '0;
            r_half_cnt   <= '0;
            r_snd        <= 1'b0;
            r_cur_note   <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_half_cnt   <= w_half_cnt_next;
            r_snd        <= w_snd_next;
            r_cur_note   <= w_cur_note_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pop             = 1'b0;
        w_sample_cnt_next = r_sample_cnt;
        w_half_cnt_next   = r_half_cnt;
        w_snd_next        = r_snd;
        w_cur_note_next   = r_cur_note;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next      = S_PLAY;
                    w_pop             = 1'b1;
                    w_sample_cnt_next = '0;
                    w_half_cnt_next   = '0;
                    w_snd_next        = 1'b1;
                    w_cur_note_next   = r_fifo_mem[r_rd_ptr];
                end
            end
            S_PLAY: begin
                // Pitch runs on clk, independent of sample ticks.
                if (r_half_cnt == w_delay) begin
                    w_half_cnt_next = '0;
                    w_snd_next      = !r_snd;
                end else begin
                    w_half_cnt_next = r_half_cnt + 1'b1;
                end
                if (w_tick) begin
                    if (r_sample_cnt == NOTE_LAST) begin
                        w_state_next      = S_GAP;
                        w_sample_cnt_next = '0;
                        w_cur_note_next   = 4'd0;
                    end else begin
                        w_sample_cnt_next = r_sample_cnt + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_sample_cnt == GAP_LAST) begin
                        w_sample_cnt_next = '0;
                        if (!w_empty) begin
                            w_state_next    = S_PLAY;
                            w_pop           = 1'b1;
                            w_half_cnt_next = '0;
                            w_snd_next      = 1'b1;
                            w_cur_note_next = r_fifo_mem[r_rd_ptr];
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_sample_cnt_next = r_sample_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef TILE_TONE_ENVELOPE_EN
    localparam logic signed [31:0] AMP_S    = AMPLITUDE;
    localparam logic [31:0]        AMP_HALF = AMP_S >>> 1;
    assign w_mag = (r_sample_cnt >= CNT_W'(NOTE_SAMPLES / 2)) ? AMP_HALF : AMPLITUDE;
`else
    assign w_mag = AMPLITUDE;
`endif

    assign bus.sample_out      = (r_state == S_PLAY) ? (r_snd ? w_mag : -w_mag) : 32'd0;
    assign bus.write_audio_out = w_tick;
    assign bus.note_ready      = !w_full;
    assign bus.busy            = (r_state != S_IDLE) || !w_empty;
    assign bus.cur_note        = r_cur_note;

endmodule

// File: tb/tb_tile_tone_player.sv
// Scoreboard bench for tile_tone_player: stimulus queues expected ticks, a monitor checks them.
module tb_tile_tone_player;

    localparam int          NS      = 8;
    localparam int          GS      = 2;
    localparam logic [31:0] AMP     = 32'd10000000;
    localparam logic [31:0] NEG_AMP = 32'hFF676980;

    typedef struct {
        logic [3:0]  note;
        logic [31:0] sample;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    bit   stall  = 1'b0;
    bit   in_run = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    tile_tone_player_if bus ();

    tile_tone_player #(
        .NOTE_SAMPLES (NS),
        .GAP_SAMPLES  (GS),
        .AMPLITUDE    (AMP),
        .FIFO_DEPTH   (4)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endfunction

    function automatic logic [31:0] exp_mag(int k);
`ifdef TILE_TONE_ENVELOPE_EN
        return (k >= NS / 2) ? 32'd5000000 : AMP;
`else
        return AMP;
`endif
    endfunction

    // Audio controller model: room for a sample every 4th clock unless stalled.
    initial begin
        bus.audio_out_allowed = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            bus.audio_out_allowed = !stall && (cyc % 4 == 0);
        end
    end

    // Monitor: every tick of a note run (PLAY plus its trailing GAP) is checked.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_run = 1'b0;
            end else if (bus.write_audio_out && (bus.cur_note != 4'd0 || (in_run && bus.busy))) begin
                if (bus.cur_note != 4'd0) in_run = 1'b1;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL tick_unexpected: got note %0d sample %0h, expected no tick", bus.cur_note, bus.sample_out);
                end else begin
                    e = sb.pop_front();
                    chk("tick_note", {28'd0, bus.cur_note}, {28'd0, e.note});
                    chk("tick_sample", bus.sample_out, e.sample);
                end
            end else if (!bus.busy) begin
                in_run = 1'b0;
            end
        end
    end

    task automatic push_note(input logic [3:0] n, input bit neg);
        chk("ready_before_push", {31'd0, bus.note_ready}, 32'd1);
        bus.note_valid = 1'b1;
        bus.note       = n;
        @(posedge clk);
        if (n != 4'd0) begin
            for (int k = 0; k < NS; k++) begin
                sb.push_back('{n, neg ? (32'd0 - exp_mag(k)) : exp_mag(k)});
            end
            for (int g = 0; g < GS; g++) begin
                sb.push_back('{4'd0, 32'd0});
            end
        end
        $display("push note %0d", n);
        @(negedge clk);
        bus.note_valid = 1'b0;
    endtask

    task automatic wait_cur(input logic [3:0] n, input int budget);
        int t = 0;
        while (bus.cur_note != n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("wait_cur_note", {28'd0, bus.cur_note}, {28'd0, n});
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((bus.busy || sb.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_busy", {31'd0, bus.busy}, 32'd0);
        chk("drain_queue", sb.size(), 32'd0);
    endtask

    initial begin
        int k;
        bus.note_valid = 1'b0;
        bus.note       = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.note_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_sample", bus.sample_out, 32'd0);
        @(posedge clk);
        #2 resetn = 1'b1;

        // Reset and idle
        repeat (20) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, bus.note_ready}, 32'd1);
            chk("idle_busy", {31'd0, bus.busy}, 32'd0);
            chk("idle_sample", bus.sample_out, 32'd0);
            chk("idle_write", {31'd0, bus.write_audio_out}, {31'd0, bus.audio_out_allowed});
        end

        // Single note: PLAY two cycles after the push cycle
        push_note(4'd1, 1'b0);
        chk("single_n1_cur", {28'd0, bus.cur_note}, 32'd0);
        chk("single_n1_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("single_n2_cur", {28'd0, bus.cur_note}, 32'd1);
        chk("single_n2_sample", bus.sample_out, AMP);
        wait_idle(400);
        chk("single_cur_after", {28'd0, bus.cur_note}, 32'd0);

        // Full FIFO
        repeat (3) @(negedge clk);
        for (int n = 3; n <= 7; n++) push_note(4'(n), 1'b0);
        chk("full_ready_low", {31'd0, bus.note_ready}, 32'd0);
        wait_idle(1500);

        // Rest note
        push_note(4'd0, 1'b0);
        repeat (5) @(negedge clk);
        chk("rest_busy", {31'd0, bus.busy}, 32'd0);
        chk("rest_cur", {28'd0, bus.cur_note}, 32'd0);

        // Reset mid-note with two queued
        push_note(4'd5, 1'b0);
        push_note(4'd6, 1'b0);
        push_note(4'd7, 1'b0);
        wait_cur(4'd5, 50);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        sb.delete();
        #1;
        chk("midrst_ready", {31'd0, bus.note_ready}, 32'd1);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_cur", {28'd0, bus.cur_note}, 32'd0);
        chk("midrst_sample", bus.sample_out, 32'd0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (200) @(negedge clk);
        chk("postrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("postrst_cur", {28'd0, bus.cur_note}, 32'd0);

        // Stalled handshake, long enough to see the first pitch toggle
        stall = 1'b1;
        repeat (3) @(negedge clk);
        push_note(4'd1, 1'b1);
        wait_cur(4'd1, 10);
        chk("stall_entry_sample", bus.sample_out, AMP);
        k = 0;
        repeat (100) begin
            @(negedge clk);
            k++;
        end
        chk("stall_write", {31'd0, bus.write_audio_out}, 32'd0);
        chk("stall_cur", {28'd0, bus.cur_note}, 32'd1);
        chk("stall_sample", bus.sample_out, AMP);
        while (bus.sample_out != NEG_AMP && k < 40000) begin
            @(negedge clk);
            k++;
        end
        chk("toggle_clks", k, 32'd35769);
        stall = 1'b0;
        wait_idle(500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
